// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants: opcodes, funct3/funct7 fields and ALU operation codes.
package rv_decode_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_PASS_B = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_op_e;

   // M-extension funct3 order matches the MUL..REMU code order, so it is a plain offset.
   function automatic alu_op_e muldiv_op(input logic [2:0] f3);
      return alu_op_e'(5'd11 + {2'b00, f3});
   endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder; RV_M_EXT_EN adds the M-extension OP group.
module rv_decoder
   import rv_decode_pkg::*;
(
   input  logic [31:0] instr,
   output logic        dec_we,
   output logic        dec_use_imm,
   output logic        dec_use_pc,
   output logic [4:0]  dec_alu_op,
   output logic [31:0] dec_imm,
   output logic [4:0]  dec_rd,
   output logic [4:0]  dec_rs1,
   output logic [4:0]  dec_rs2,
   output logic        dec_illegal
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [31:0] shamt_imm;
   alu_op_e    op;

   assign opcode    = instr[6:0];
   assign f3        = instr[14:12];
   assign f7        = instr[31:25];
   assign shamt_imm = {27'b0, instr[24:20]};

   assign dec_rd  = instr[11:7];
   assign dec_rs1 = instr[19:15];
   assign dec_rs2 = instr[24:20];

   always_comb begin
      op          = ALU_ADD;
      dec_illegal = 1'b1;
      dec_use_imm = 1'b0;
      dec_use_pc  = 1'b0;
      dec_imm     = '0;
      dec_we      = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            dec_illegal = 1'b0;
            dec_use_imm = 1'b1;
            dec_imm     = {{20{instr[31]}}, instr[31:20]};
            case (f3)
               F3_ADD_SUB: op = ALU_ADD;
               F3_SLT:     op = ALU_SLT;
               F3_SLTU:    op = ALU_SLTU;
               F3_XOR:     op = ALU_XOR;
               F3_OR:      op = ALU_OR;
               F3_AND:     op = ALU_AND;
               F3_SLL: begin
                  op          = ALU_SLL;
                  dec_imm     = shamt_imm;
                  dec_illegal = (f7 != F7_BASE);
               end
               default: begin
                  dec_imm = shamt_imm;
                  if (f7 == F7_BASE)     op = ALU_SRL;
                  else if (f7 == F7_ALT) op = ALU_SRA;
                  else                   dec_illegal = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               dec_illegal = 1'b0;
               case (f3)
                  F3_ADD_SUB: op = ALU_ADD;
                  F3_SLL:     op = ALU_SLL;
                  F3_SLT:     op = ALU_SLT;
                  F3_SLTU:    op = ALU_SLTU;
                  F3_XOR:     op = ALU_XOR;
                  F3_SRL_SRA: op = ALU_SRL;
                  F3_OR:      op = ALU_OR;
                  default:    op = ALU_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               if (f3 == F3_ADD_SUB) begin
                  op          = ALU_SUB;
                  dec_illegal = 1'b0;
               end else if (f3 == F3_SRL_SRA) begin
                  op          = ALU_SRA;
                  dec_illegal = 1'b0;
               end
            end else if (f7 == F7_MULDIV) begin
`ifdef RV_M_EXT_EN
               op          = muldiv_op(f3);
               dec_illegal = 1'b0;
`else
               dec_illegal = 1'b1;
`endif
            end
         end
         OPC_LUI: begin
            dec_illegal = 1'b0;
            dec_use_imm = 1'b1;
            op          = ALU_PASS_B;
            dec_imm     = {instr[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            dec_illegal = 1'b0;
            dec_use_imm = 1'b1;
            dec_use_pc  = 1'b1;
            op          = ALU_ADD;
            dec_imm     = {instr[31:12], 12'b0};
         end
         default: dec_illegal = 1'b1;
      endcase

      // Illegal bundles carry a neutral payload so nothing downstream acts on stale fields.
      if (dec_illegal) begin
         op          = ALU_ADD;
         dec_imm     = '0;
         dec_use_imm = 1'b0;
         dec_use_pc  = 1'b0;
      end
      dec_we = !dec_illegal && (dec_rd != 5'd0);
   end

   assign dec_alu_op = op;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, flush and saturating illegal counter.
// Define RV_M_EXT_EN to decode the M-extension OP group (see rv_decoder).
module decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [XLEN-1:0]     in_pc,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_we,
   output logic                out_use_imm,
   output logic                out_use_pc,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic [XLEN-1:0]     out_imm,
   output logic [4:0]          out_rd,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [XLEN-1:0]     out_pc,
   output logic                out_illegal,
   output logic [CNT_W-1:0]    illegal_count
);

   if (XLEN != 32) begin : g_xlen_check
      $error("decode_stage: only XLEN=32 is supported");
   end

   logic        dec_we, dec_use_imm, dec_use_pc, dec_illegal;
   logic [4:0]  dec_alu_op, dec_rd, dec_rs1, dec_rs2;
   logic [31:0] dec_imm;

   rv_decoder u_dec (
      .instr       (in_instr),
      .dec_we      (dec_we),
      .dec_use_imm (dec_use_imm),
      .dec_use_pc  (dec_use_pc),
      .dec_alu_op  (dec_alu_op),
      .dec_imm     (dec_imm),
      .dec_rd      (dec_rd),
      .dec_rs1     (dec_rs1),
      .dec_rs2     (dec_rs2),
      .dec_illegal (dec_illegal)
   );

   logic                valid_q, valid_d;
   logic                we_q, we_d, use_imm_q, use_imm_d, use_pc_q, use_pc_d;
   logic                illegal_q, illegal_d;
   logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
   logic [XLEN-1:0]     imm_q, imm_d, pc_q, pc_d;
   logic [4:0]          rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                xfer;

   assign in_ready = !flush && (!valid_q || out_ready);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      valid_d   = valid_q;
      we_d      = we_q;
      use_imm_d = use_imm_q;
      use_pc_d  = use_pc_q;
      alu_op_d  = alu_op_q;
      imm_d     = imm_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      pc_d      = pc_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;

      // flush blocks in_ready, so xfer can never coincide with it.
      if (flush) begin
         valid_d = 1'b0;
      end else if (xfer) begin
         valid_d   = 1'b1;
         we_d      = dec_we;
         use_imm_d = dec_use_imm;
         use_pc_d  = dec_use_pc;
         alu_op_d  = ALU_OP_W'(dec_alu_op);
         imm_d     = XLEN'(dec_imm);
         rd_d      = dec_rd;
         rs1_d     = dec_rs1;
         rs2_d     = dec_rs2;
         pc_d      = in_pc;
         illegal_d = dec_illegal;
         if (dec_illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
         use_imm_q <= 1'b0;
         use_pc_q  <= 1'b0;
         alu_op_q  <= '0;
         imm_q     <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         pc_q      <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         we_q      <= we_d;
         use_imm_q <= use_imm_d;
         use_pc_q  <= use_pc_d;
         alu_op_q  <= alu_op_d;
         imm_q     <= imm_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         pc_q      <= pc_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_we        = we_q;
   assign out_use_imm   = use_imm_q;
   assign out_use_pc    = use_pc_q;
   assign out_alu_op    = alu_op_q;
   assign out_imm       = imm_q;
   assign out_rd        = rd_q;
   assign out_rs1       = rs1_q;
   assign out_rs2       = rs2_q;
   assign out_pc        = pc_q;
   assign out_illegal   = illegal_q;
   assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus stall, flush, saturation and reset sequences.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_we, out_use_imm, out_use_pc, out_illegal;
   logic [4:0]  out_alu_op, out_rd, out_rs1, out_rs2;
   logic [31:0] out_imm, out_pc;
   logic [15:0] illegal_count;

   logic        s_in_ready, s_out_valid, s_out_we, s_out_use_imm, s_out_use_pc, s_out_illegal;
   logic [4:0]  s_out_alu_op, s_out_rd, s_out_rs1, s_out_rs2;
   logic [31:0] s_out_imm, s_out_pc;
   logic [2:0]  s_illegal_count;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .ALU_OP_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_we(out_we), .out_use_imm(out_use_imm),
      .out_use_pc(out_use_pc), .out_alu_op(out_alu_op), .out_imm(out_imm),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc),
      .out_illegal(out_illegal), .illegal_count(illegal_count)
   );

   // Narrow-counter copy so saturation is reachable in a few cycles.
   decode_stage #(.XLEN(32), .ALU_OP_W(5), .CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_we(s_out_we), .out_use_imm(s_out_use_imm),
      .out_use_pc(s_out_use_pc), .out_alu_op(s_out_alu_op), .out_imm(s_out_imm),
      .out_rd(s_out_rd), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_pc(s_out_pc),
      .out_illegal(s_out_illegal), .illegal_count(s_illegal_count)
   );

   typedef struct {
      logic [31:0] instr;
      logic        we, use_imm, use_pc;
      logic [4:0]  alu;
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      logic        ill;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_cnt = 0;

   localparam logic [88:0] ILL_MASK = {1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0,
                                       5'h1f, 5'h1f, 5'h1f, 32'hffffffff, 1'b1};

   function automatic vec_t mk(input logic [31:0] instr, input logic we, input logic ui,
                               input logic up, input logic [4:0] alu, input logic [31:0] imm,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic ill);
      vec_t v;
      v.instr = instr; v.we = we; v.use_imm = ui; v.use_pc = up; v.alu = alu;
      v.imm = imm; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.ill = ill;
      return v;
   endfunction

   task automatic chk(input string name, input logic [88:0] act, input logic [88:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [88:0] bundle();
      return {out_valid, out_we, out_use_imm, out_use_pc, out_alu_op, out_imm,
              out_rd, out_rs1, out_rs2, out_pc, out_illegal};
   endfunction

   task automatic chk_counts(input string name);
      int sat;
      sat = (exp_cnt > 7) ? 7 : exp_cnt;
      chk({name, "_cnt"}, 89'(illegal_count), 89'(exp_cnt));
      chk({name, "_satcnt"}, 89'(s_illegal_count), 89'(sat));
   endtask

   initial begin
      logic [88:0] exp_b, held;

      vecs[0]  = mk(32'hFFF00093, 1, 1, 0, 5'd0,  32'hFFFFFFFF, 5'd1,  5'd0,  5'd31, 0); // ADDI x1,x0,-1
      vecs[1]  = mk(32'h402081B3, 1, 0, 0, 5'd1,  32'h0,        5'd3,  5'd1,  5'd2,  0); // SUB
      vecs[2]  = mk(32'h007302B3, 1, 0, 0, 5'd0,  32'h0,        5'd5,  5'd6,  5'd7,  0); // ADD
      vecs[3]  = mk(32'h0055B513, 1, 1, 0, 5'd4,  32'h5,        5'd10, 5'd11, 5'd5,  0); // SLTIU
      vecs[4]  = mk(32'h40315113, 1, 1, 0, 5'd7,  32'h3,        5'd2,  5'd2,  5'd3,  0); // SRAI
      vecs[5]  = mk(32'h40311113, 0, 0, 0, 5'd0,  32'h0,        5'd2,  5'd2,  5'd3,  1); // SLLI bad f7
      vecs[6]  = mk(32'h12345237, 1, 1, 0, 5'd10, 32'h12345000, 5'd4,  5'd8,  5'd3,  0); // LUI
      vecs[7]  = mk(32'hFFFFF317, 1, 1, 1, 5'd0,  32'hFFFFF000, 5'd6,  5'd31, 5'd31, 0); // AUIPC
      vecs[8]  = mk(32'h00000013, 0, 1, 0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  0); // NOP rd=0
      vecs[9]  = mk(32'hFFFFFFFF, 0, 0, 0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 1); // all ones
`ifdef RV_M_EXT_EN
      vecs[10] = mk(32'h027302B3, 1, 0, 0, 5'd11, 32'h0,        5'd5,  5'd6,  5'd7,  0); // MUL
      vecs[11] = mk(32'h023150B3, 1, 0, 0, 5'd16, 32'h0,        5'd1,  5'd2,  5'd3,  0); // DIVU
`else
      vecs[10] = mk(32'h027302B3, 0, 0, 0, 5'd0,  32'h0,        5'd5,  5'd6,  5'd7,  1);
      vecs[11] = mk(32'h023150B3, 0, 0, 0, 5'd0,  32'h0,        5'd1,  5'd2,  5'd3,  1);
`endif
      vecs[12] = mk(32'h403150B3, 1, 0, 0, 5'd7,  32'h0,        5'd1,  5'd2,  5'd3,  0); // SRA
      vecs[13] = mk(32'h009473B3, 1, 0, 0, 5'd9,  32'h0,        5'd7,  5'd8,  5'd9,  0); // AND
      vecs[14] = mk(32'h40001033, 0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  1); // f7 alt, f3=001
      vecs[15] = mk(32'h00002003, 0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  1); // LOAD opcode
      vecs[16] = mk(32'h8000C093, 1, 1, 0, 5'd5,  32'hFFFFF800, 5'd1,  5'd1,  5'd0,  0); // XORI -2048

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      chk("reset_bundle", bundle(), '0);
      chk_counts("reset");
      step;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_in_ready", 89'(in_ready), 89'(1));

      // Vector table, back-to-back with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         in_valid = 1'b1;
         in_instr = vecs[i].instr;
         in_pc    = 32'h1000 + 32'(i * 4);
         step;
         if (vecs[i].ill) exp_cnt++;
         exp_b = {1'b1, vecs[i].we, vecs[i].use_imm, vecs[i].use_pc, vecs[i].alu, vecs[i].imm,
                  vecs[i].rd, vecs[i].rs1, vecs[i].rs2, in_pc, vecs[i].ill};
         if (vecs[i].ill) chk($sformatf("vec%0d", i), bundle() & ILL_MASK, exp_b & ILL_MASK);
         else             chk($sformatf("vec%0d", i), bundle(), exp_b);
         chk_counts($sformatf("vec%0d", i));
      end
      in_valid = 1'b0;
      step;
      chk("drain_valid", 89'(out_valid), 89'(0));

      // Stall: SUB held for 3 cycles while ADD is offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h402081B3;
      in_pc     = 32'h2000;
      step;
      held = {1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h0, 5'd3, 5'd1, 5'd2, 32'h2000, 1'b0};
      chk("stall_first", bundle(), held);
      in_instr = 32'h007302B3;
      in_pc    = 32'h2004;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall_in_ready%0d", k), 89'(in_ready), 89'(0));
         step;
         chk($sformatf("stall_hold%0d", k), bundle(), held);
      end
      out_ready = 1'b1;
      #1;
      chk("stall_release_ready", 89'(in_ready), 89'(1));
      step;
      chk("stall_next", bundle(),
          {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd7, 32'h2004, 1'b0});
      in_valid = 1'b0;
      step;
      chk("stall_drain", 89'(out_valid), 89'(0));
      chk_counts("stall");

      // Flush beats in_valid on a held bundle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h402081B3;
      step;
      chk("flush_held", 89'(out_valid), 89'(1));
      flush    = 1'b1;
      in_instr = 32'hFFFFFFFF;
      #1;
      chk("flush_in_ready", 89'(in_ready), 89'(0));
      step;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", 89'(out_valid), 89'(0));
      chk_counts("flush");
      step;
      chk("flush_stays", 89'(out_valid), 89'(0));

      // Saturation of the narrow counter
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'hFFFFFFFF;
      for (int k = 0; k < 9; k++) begin
         step;
         exp_cnt++;
         chk_counts($sformatf("sat%0d", k));
      end
      in_valid = 1'b0;
      step;

      // Asynchronous reset during a stall
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFFFFFFF;
      step;
      exp_cnt++;
      in_valid = 1'b0;
      chk("areset_held", {out_valid, out_illegal}, {87'b0, 2'b11});
      #2 rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk("areset_bundle", bundle(), '0);
      chk_counts("areset");
      #10 rst_n = 1'b1;
      step;
      chk("areset_after", {out_valid, in_ready}, 89'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath and immediate width (32 only; other values are rejected at elaboration).
REQ-002 SHALL have parameter ALU_OP_W, 5, width of out_alu_op.
REQ-003 SHALL have parameter CNT_W, 16, width of illegal_count.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  instruction offered.
REQ-007 SHALL have port in_ready  output  1  stage accepts this cycle.
REQ-008 SHALL have port in_instr  input  32  raw instruction.
REQ-009 SHALL have port in_pc  input  XLEN  instruction address.
REQ-010 SHALL have port flush  input  1  discard held decode.
REQ-011 SHALL have port out_valid  output  1  decoded bundle valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts.
REQ-013 SHALL have output bundle ports: out_we 1, out_use_imm 1, out_use_pc 1, out_alu_op ALU_OP_W, out_imm XLEN, out_rd 5, out_rs1 5, out_rs2 5, out_pc XLEN, out_illegal 1.
REQ-014 SHALL have port illegal_count  output  CNT_W  number of illegal instructions accepted.

Function
REQ-015 SHALL be one registered stage; accepted instruction appears on outputs the next cycle (latency 1).
REQ-016 SHALL drive in_ready = !flush && (!out_valid || out_ready); transfer on in_valid && in_ready.
REQ-017 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid when the held bundle is consumed without a new transfer in the same cycle.
REQ-019 SHALL, on flush, clear out_valid next cycle; flush overrides a simultaneous in_valid, and no transfer occurs.
REQ-020 SHALL decode OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI with imm = sign-extended instr[31:20].
REQ-021 SHALL decode SLLI/SRLI/SRAI with imm = zero-extended instr[24:20]; SHALL flag illegal if funct7 is not 0000000 (0100000 for SRAI).
REQ-022 SHALL decode OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; use_imm=0.
REQ-023 SHALL decode LUI with alu_op PASS_B, imm={instr[31:12],12'b0}.
REQ-024 SHALL decode AUIPC with alu_op ADD, use_pc=1, use_imm=1, and the same imm as LUI.
REQ-025 SHALL, for any other opcode/funct combination, set out_illegal=1 and out_we=0, and still present the bundle with out_valid.
REQ-026 SHALL force out_we=0 when rd=0.
REQ-027 SHALL increment illegal_count on each accepted illegal instruction, saturating at all-ones.
REQ-028 SHALL set rd, rs1, and rs2 from bits [11:7], [19:15], and [24:20] for every instruction.

Reset
REQ-029 SHALL, on rst_n low, clear out_valid, all bundle outputs, and illegal_count to 0 immediately; in_ready=1 after release.
REQ-030 SHALL discard a held bundle when reset asserts mid-stall.

Configuration
REQ-031 SHALL, with RV_M_EXT_EN defined, decode OP with funct7=0000001 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, and REMU (alu_op 11-18).
REQ-032 SHALL, without RV_M_EXT_EN, flag funct7=0000001 as illegal.

Structure
REQ-033 SHALL take the opcode constants, funct3/funct7 constants, and ALU op codes from shared package rv_decode_pkg: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
REQ-034 SHALL implement decoding in a combinational sub-module rv_decoder, with decode_stage adding the register, handshake, and counter.

Verification
REQ-035 SHALL verify: ADDI x1,x0,-1 (0xFFF00093) -> next cycle out_we=1, alu_op=0, imm=0xFFFFFFFF, rd=1.
REQ-036 SHALL verify: SUB x3,x1,x2 (0x402081B3) with out_ready=0 for 3 cycles -> bundle stable, in_ready=0, single transfer on release.
REQ-037 SHALL verify: 0xFFFFFFFF accepted -> out_illegal=1, out_we=0, illegal_count 0->1; with illegal_count preloaded at 0xFFFF, it remains at 0xFFFF.
REQ-038 SHALL verify: flush with in_valid=1 and a held bundle -> out_valid=0 next cycle, no transfer.
REQ-039 SHALL verify: MUL x5,x6,x7 (0x027302B3) -> alu_op=11 with RV_M_EXT_EN; out_illegal=1 without it.
REQ-040 SHALL verify: rst_n low during a stall -> out_valid=0 asynchronously, illegal_count=0.
